// File: rtl/regfile_write_arbiter.sv
// Muxes WB writes (A, 1-cycle, never stalls) and long-latency results (B, queued in-order) onto the RF write port.
// B is backpressured by b_ready (= not full); starved B raises a registered stall_req until its next pop.
module regfile_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                   clock_in,
  input  logic                   reset,
  input  logic                   a_valid,
  input  logic [ADDR_W-1:0]      a_reg,
  input  logic [DATA_W-1:0]      a_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [ADDR_W-1:0]      b_reg,
  input  logic [DATA_W-1:0]      b_data,
  input  logic [ADDR_W-1:0]      q_reg1,
  input  logic [ADDR_W-1:0]      q_reg2,
  output logic                   hazard1,
  output logic                   hazard2,
  output logic                   stall_req,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]    FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [ADDR_W-1:0]   entryReg  [DEPTH];
  logic [DATA_W-1:0]   entryData [DEPTH];
  logic [DEPTH-1:0]    entryLive;
  logic [PTR_W-1:0]    rdPtr, wrPtr;
  logic [CNT_W-1:0]    count;
  logic [STARVE_W-1:0] starveCnt, starveNext;
  logic                grantA, pushEn, popEn, fifoEmpty;

  assign fifoEmpty  = (count == '0);
  assign b_ready    = (count != FULL_CNT);
  assign grantA     = a_valid && (a_reg != '0);
  assign pushEn     = b_valid && b_ready;
  assign popEn      = !grantA && !fifoEmpty;
  assign fifo_count = count;

  always_ff @(posedge clock_in) begin
    if (pushEn) begin
      entryReg[wrPtr]  <= b_reg;
      entryData[wrPtr] <= b_data;
    end
  end

  always_comb begin
    starveNext = starveCnt;
    if (popEn || fifoEmpty)
      starveNext = '0;
    else if (starveCnt != STARVE_LIM)
      starveNext = starveCnt + STARVE_W'(1);
  end

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      entryLive <= '0;
      rdPtr     <= '0;
      wrPtr     <= '0;
      count     <= '0;
      starveCnt <= '0;
      stall_req <= 1'b0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
    end else begin
      // A grant kills older B results to the same register, including one entering this edge
      for (int i = 0; i < DEPTH; i++) begin
        if (pushEn && wrPtr == PTR_W'(i))
          entryLive[i] <= (b_reg != '0) && !(grantA && a_reg == b_reg);
        else if (popEn && rdPtr == PTR_W'(i))
          entryLive[i] <= 1'b0;
        else if (grantA && entryReg[i] == a_reg)
          entryLive[i] <= 1'b0;
      end
      if (pushEn) wrPtr <= wrPtr + PTR_W'(1);
      if (popEn)  rdPtr <= rdPtr + PTR_W'(1);
      count     <= count + CNT_W'(pushEn) - CNT_W'(popEn);
      starveCnt <= starveNext;
      stall_req <= popEn ? 1'b0 : (stall_req || starveNext == STARVE_LIM);

      if (grantA) begin
        rf_we    <= 1'b1;
        rf_waddr <= a_reg;
        rf_wdata <= a_data;
      end else if (popEn) begin
        rf_we <= entryLive[rdPtr];
        if (entryLive[rdPtr]) begin
          rf_waddr <= entryReg[rdPtr];
          rf_wdata <= entryData[rdPtr];
        end
      end else begin
        rf_we <= 1'b0;
      end
    end
  end

  always_comb begin
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entryLive[i] && entryReg[i] == q_reg1) hazard1 = 1'b1;
      if (entryLive[i] && entryReg[i] == q_reg2) hazard2 = 1'b1;
    end
    if (q_reg1 == '0) hazard1 = 1'b0;
    if (q_reg2 == '0) hazard2 = 1'b0;
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Random and directed stimulus checked each cycle against a queue-based model of the arbiter.
module tb_regfile_write_arbiter;
  localparam int DATA_W = 32, ADDR_W = 5, DEPTH = 2, STARVE_MAX = 3;

  logic clock_in = 1'b0;
  logic reset = 1'b0;
  logic a_valid = 1'b0, b_valid = 1'b0;
  logic [ADDR_W-1:0] a_reg = '0, b_reg = '0, q_reg1 = '0, q_reg2 = '0;
  logic [DATA_W-1:0] a_data = '0, b_data = '0;
  logic b_ready, hazard1, hazard2, stall_req, rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [$clog2(DEPTH):0] fifo_count;

  always #5 clock_in = ~clock_in;

  regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clock_in(clock_in), .reset(reset),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .q_reg1(q_reg1), .q_reg2(q_reg2), .hazard1(hazard1), .hazard2(hazard2),
    .stall_req(stall_req), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fifo_count(fifo_count)
  );

  typedef struct {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
    bit                live;
  } ent_t;

  ent_t              mq[$];
  bit                expWe;
  logic [ADDR_W-1:0] expAddr;
  logic [DATA_W-1:0] expData;
  int                streak;
  int                nChecks = 0;
  int                nFail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit modelHazard(input logic [ADDR_W-1:0] q);
    bit h = 1'b0;
    foreach (mq[i]) if (mq[i].live && mq[i].r == q && q != '0) h = 1'b1;
    return h;
  endfunction

  task automatic modelReset();
    mq.delete();
    expWe = 1'b0;
    expAddr = '0;
    expData = '0;
    streak = 0;
  endtask

  task automatic setIn(input bit av, input int ar, input logic [31:0] ad,
                       input bit bv, input int br, input logic [31:0] bd,
                       input int q1, input int q2);
    a_valid = av;  a_reg = ADDR_W'(ar); a_data = ad;
    b_valid = bv;  b_reg = ADDR_W'(br); b_data = bd;
    q_reg1 = ADDR_W'(q1); q_reg2 = ADDR_W'(q2);
  endtask

  task automatic checkAll();
    #1;
    chk("rf_we", 64'(rf_we), 64'(expWe));
    if (expWe) begin
      chk("rf_waddr", 64'(rf_waddr), 64'(expAddr));
      chk("rf_wdata", 64'(rf_wdata), 64'(expData));
    end
    chk("stall_req", 64'(stall_req), 64'(streak >= STARVE_MAX));
    chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
    chk("b_ready", 64'(b_ready), 64'(mq.size() < DEPTH));
    chk("hazard1", 64'(hazard1), 64'(modelHazard(q_reg1)));
    chk("hazard2", 64'(hazard2), 64'(modelHazard(q_reg2)));
  endtask

  // Apply the edge to the model, then advance the DUT to the next falling edge
  task automatic step();
    int   pre;
    bit   ga, pu, po;
    ent_t e;
    pre = mq.size();
    ga  = a_valid && a_reg != '0;
    pu  = b_valid && pre < DEPTH;
    po  = !ga && pre > 0;
    if (ga) begin
      expWe = 1'b1; expAddr = a_reg; expData = a_data;
    end else if (po) begin
      e = mq.pop_front();
      expWe = e.live;
      if (e.live) begin expAddr = e.r; expData = e.d; end
    end else begin
      expWe = 1'b0;
    end
    if (pu) begin
      e.r = b_reg; e.d = b_data; e.live = (b_reg != '0);
      mq.push_back(e);
    end
    if (ga) foreach (mq[i]) if (mq[i].r == a_reg) mq[i].live = 1'b0;
    if (po || pre == 0) streak = 0;
    else streak++;
    @(posedge clock_in);
    @(negedge clock_in);
  endtask

  initial begin
    bit heavy;
    modelReset();
    repeat (3) @(negedge clock_in);
    chk("reset_rf_we", 64'(rf_we), 64'd0);
    chk("reset_count", 64'(fifo_count), 64'd0);
    reset = 1'b1;

    // Reset then idle
    setIn(0, 0, 0, 0, 0, 0, 9, 9);
    checkAll();
    chk("idle_rf_we", 64'(rf_we), 64'd0);
    chk("idle_b_ready", 64'(b_ready), 64'd1);
    chk("idle_hazard1", 64'(hazard1), 64'd0);
    chk("idle_hazard2", 64'(hazard2), 64'd0);
    chk("idle_stall", 64'(stall_req), 64'd0);
    chk("idle_count", 64'(fifo_count), 64'd0);
    step();

    // A only, then a_reg==0
    setIn(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    checkAll(); step();
    setIn(1, 0, 32'h12345678, 0, 0, 0, 0, 0);
    checkAll();
    chk("a_we", 64'(rf_we), 64'd1);
    chk("a_waddr", 64'(rf_waddr), 64'd5);
    chk("a_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    step();
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    checkAll();
    chk("a0_we", 64'(rf_we), 64'd0);
    step();

    // B push reg 9 then drain
    setIn(0, 0, 0, 1, 9, 32'h11, 9, 0);
    checkAll(); step();
    setIn(0, 0, 0, 0, 0, 0, 9, 0);
    checkAll();
    chk("b_hazard1", 64'(hazard1), 64'd1);
    chk("b_count", 64'(fifo_count), 64'd1);
    step();
    checkAll();
    chk("b_we", 64'(rf_we), 64'd1);
    chk("b_waddr", 64'(rf_waddr), 64'd9);
    chk("b_wdata", 64'(rf_wdata), 64'h11);
    chk("b_hazard1_clear", 64'(hazard1), 64'd0);
    step();

    // Same-edge kill on reg 7
    setIn(1, 7, 32'hBB, 1, 7, 32'hAA, 7, 0);
    checkAll(); step();
    setIn(0, 0, 0, 0, 0, 0, 7, 0);
    checkAll();
    chk("kill_we", 64'(rf_we), 64'd1);
    chk("kill_wdata", 64'(rf_wdata), 64'hBB);
    chk("kill_hazard", 64'(hazard1), 64'd0);
    chk("kill_count", 64'(fifo_count), 64'd1);
    step();
    checkAll();
    chk("kill_pop_we", 64'(rf_we), 64'd0);
    chk("kill_pop_count", 64'(fifo_count), 64'd0);
    step();

    // Full and starve with A busy on reg 3
    setIn(1, 3, 32'h30, 1, 10, 32'h100, 10, 11);
    checkAll(); step();
    setIn(1, 3, 32'h31, 1, 11, 32'h101, 10, 11);
    checkAll();
    chk("full_ready1", 64'(b_ready), 64'd1);
    step();
    setIn(1, 3, 32'h32, 1, 12, 32'h102, 10, 11);
    checkAll();
    chk("full_ready0", 64'(b_ready), 64'd0);
    chk("full_count", 64'(fifo_count), 64'd2);
    chk("full_hz1", 64'(hazard1), 64'd1);
    chk("full_hz2", 64'(hazard2), 64'd1);
    chk("starve_not_yet", 64'(stall_req), 64'd0);
    step();
    setIn(1, 3, 32'h33, 0, 0, 0, 10, 11);
    checkAll();
    chk("starve_not_yet2", 64'(stall_req), 64'd0);
    step();
    setIn(0, 0, 0, 0, 0, 0, 10, 11);
    checkAll();
    chk("starve_stall", 64'(stall_req), 64'd1);
    chk("starve_a_waddr", 64'(rf_waddr), 64'd3);
    step();
    checkAll();
    chk("drain_stall_fall", 64'(stall_req), 64'd0);
    chk("drain1_waddr", 64'(rf_waddr), 64'd10);
    chk("drain1_wdata", 64'(rf_wdata), 64'h100);
    step();
    checkAll();
    chk("drain2_waddr", 64'(rf_waddr), 64'd11);
    chk("drain2_wdata", 64'(rf_wdata), 64'h101);
    chk("drain_count", 64'(fifo_count), 64'd0);
    step();

    // Reset mid-drain with two entries queued
    setIn(1, 3, 32'h40, 1, 20, 32'h200, 20, 21);
    checkAll(); step();
    setIn(1, 3, 32'h41, 1, 21, 32'h201, 20, 21);
    checkAll(); step();
    setIn(0, 0, 0, 0, 0, 0, 20, 21);
    checkAll();
    chk("pre_reset_count", 64'(fifo_count), 64'd2);
    reset = 1'b0;
    #1;
    chk("mid_reset_count", 64'(fifo_count), 64'd0);
    chk("mid_reset_we", 64'(rf_we), 64'd0);
    chk("mid_reset_waddr", 64'(rf_waddr), 64'd0);
    modelReset();
    @(posedge clock_in);
    @(negedge clock_in);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checkAll();
      chk("post_reset_we", 64'(rf_we), 64'd0);
      step();
    end

    // Randomized traffic with alternating heavy/light A phases and one mid-run reset
    for (int c = 0; c < 3000; c++) begin
      heavy = ((c / 150) % 2) == 1;
      setIn(stall_req ? ($urandom_range(0, 9) == 0) : (heavy ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 1) == 1)),
            $urandom_range(0, 7), $urandom(),
            $urandom_range(0, 9) < 6, $urandom_range(0, 7), $urandom(),
            $urandom_range(0, 7), $urandom_range(0, 7));
      if (c == 1500) begin
        reset = 1'b0;
        #1;
        chk("rand_reset_count", 64'(fifo_count), 64'd0);
        chk("rand_reset_we", 64'(rf_we), 64'd0);
        modelReset();
        @(posedge clock_in);
        @(negedge clock_in);
        reset = 1'b1;
      end else begin
        checkAll();
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
